// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand-forwarding select and load-use stall unit for the lc3b pipeline
module hazard_scoreboard #(
    parameter int REG_W          = 3,
    parameter int N_FWD          = 2,
    parameter int LOAD_RES_STAGE = 2,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = $clog2(N_FWD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_advance,
    input  logic             flush,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_sr1,
    input  logic [REG_W-1:0] dec_sr2,
    input  logic             dec_sr1use,
    input  logic             dec_sr2use,
    input  logic [REG_W-1:0] dec_dest,
    input  logic             dec_load_regfile,
    input  logic             dec_is_load,
    output logic             load_use_stall,
    output logic [SEL_W-1:0] fwd_sel_sr1,
    output logic [SEL_W-1:0] fwd_sel_sr2,
    output logic [CNT_W-1:0] stall_count
);

    logic             valid [N_FWD];
    logic [REG_W-1:0] dest  [N_FWD];
    logic             wr    [N_FWD];
    logic             is_ld [N_FWD];

    logic [SEL_W-1:0] cand_sr1, cand_sr2;
    logic             early_sr1, early_sr2, bubble;

    // Resolve each source against the shadow stages; scanning oldest to youngest lets the youngest match win
    always_comb begin
        cand_sr1  = '0;
        cand_sr2  = '0;
        early_sr1 = 1'b0;
        early_sr2 = 1'b0;
        for (int s = N_FWD - 1; s >= 0; s--) begin
            if (dec_valid && dec_sr1use && valid[s] && wr[s] && dest[s] == dec_sr1) begin
                cand_sr1  = SEL_W'(s + 1);
                early_sr1 = is_ld[s] && (s + 1 < LOAD_RES_STAGE);
            end
            if (dec_valid && dec_sr2use && valid[s] && wr[s] && dest[s] == dec_sr2) begin
                cand_sr2  = SEL_W'(s + 1);
                early_sr2 = is_ld[s] && (s + 1 < LOAD_RES_STAGE);
            end
        end
        load_use_stall = !flush && (early_sr1 || early_sr2);
        bubble         = load_use_stall || flush || !dec_valid;
    end

    // Shadow pipeline and registered forwarding selects advance with the datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < N_FWD; s++) begin
                valid[s] <= 1'b0;
                dest[s]  <= '0;
                wr[s]    <= 1'b0;
                is_ld[s] <= 1'b0;
            end
            fwd_sel_sr1 <= '0;
            fwd_sel_sr2 <= '0;
        end else if (pipe_advance) begin
            for (int s = N_FWD - 1; s > 0; s--) begin
                valid[s] <= valid[s-1];
                dest[s]  <= dest[s-1];
                wr[s]    <= wr[s-1];
                is_ld[s] <= is_ld[s-1];
            end
            valid[0]    <= !bubble;
            dest[0]     <= dec_dest;
            wr[0]       <= dec_load_regfile;
            is_ld[0]    <= dec_is_load;
            fwd_sel_sr1 <= bubble ? '0 : cand_sr1;
            fwd_sel_sr2 <= bubble ? '0 : cand_sr2;
        end
    end

    // Saturating count of cycles in which a stall bubble actually enters EX
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (pipe_advance && load_use_stall && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus checked every cycle against an in-flight history model
module tb_hazard_scoreboard;

    localparam int N_FWD = 2;
    localparam int LRS   = 2;

    logic clk = 1'b0, reset = 1'b1, adv = 1'b1, flush = 1'b0, dv = 1'b0;
    logic [2:0] sr1 = '0, sr2 = '0, dst = '0;
    logic u1 = 1'b0, u2 = 1'b0, lr = 1'b0, ld = 1'b0;

    logic        stall, stall4;
    logic [1:0]  sel1, sel2, sel1b, sel2b;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .pipe_advance(adv), .flush(flush), .dec_valid(dv),
        .dec_sr1(sr1), .dec_sr2(sr2), .dec_sr1use(u1), .dec_sr2use(u2), .dec_dest(dst),
        .dec_load_regfile(lr), .dec_is_load(ld), .load_use_stall(stall),
        .fwd_sel_sr1(sel1), .fwd_sel_sr2(sel2), .stall_count(cnt)
    );

    hazard_scoreboard #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .pipe_advance(adv), .flush(flush), .dec_valid(dv),
        .dec_sr1(sr1), .dec_sr2(sr2), .dec_sr1use(u1), .dec_sr2use(u2), .dec_dest(dst),
        .dec_load_regfile(lr), .dec_is_load(ld), .load_use_stall(stall4),
        .fwd_sel_sr1(sel1b), .fwd_sel_sr2(sel2b), .stall_count(cnt4)
    );

    always #5 clk = ~clk;

    int n_tot = 0, n_pass = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // History model: hist[0] is the youngest instruction that entered EX
    typedef struct packed {
        logic       v;
        logic [2:0] d;
        logic       w;
        logic       l;
    } ent_t;
    ent_t hist[$];
    int m_sel1 = 0, m_sel2 = 0, m_cnt = 0, m_cnt4 = 0;

    function automatic void resolve(input logic [2:0] src, input logic use_, output int sel, output bit early);
        sel = 0;
        early = 1'b0;
        if (!dv || !use_) return;
        foreach (hist[i])
            if (hist[i].v && hist[i].w && hist[i].d == src) begin
                sel = i + 1;
                early = hist[i].l && (i + 1 < LRS);
                return;
            end
    endfunction

    function automatic bit m_stall();
        int s;
        bit e1, e2;
        resolve(sr1, u1, s, e1);
        resolve(sr2, u2, s, e2);
        return !flush && (e1 || e2);
    endfunction

    always @(posedge clk) begin
        int s1, s2;
        bit e1, e2, st, bub;
        ent_t e;
        if (reset) begin
            hist.delete();
            m_sel1 = 0; m_sel2 = 0; m_cnt = 0; m_cnt4 = 0;
        end else if (adv) begin
            resolve(sr1, u1, s1, e1);
            resolve(sr2, u2, s2, e2);
            st = !flush && (e1 || e2);
            if (st) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            bub = st || flush || !dv;
            e.v = !bub; e.d = dst; e.w = lr; e.l = ld;
            hist.push_front(e);
            if (hist.size() > N_FWD) void'(hist.pop_back());
            m_sel1 = bub ? 0 : s1;
            m_sel2 = bub ? 0 : s2;
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("stall", stall, m_stall());
            chk("stall4", stall4, m_stall());
            chk("sel1", sel1, m_sel1);
            chk("sel2", sel2, m_sel2);
            chk("count", cnt, m_cnt);
            chk("count4", cnt4, m_cnt4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic v, input logic [2:0] d, input logic w, input logic l,
                       input logic [2:0] a, input logic ua, input logic [2:0] b, input logic ub);
        dv = v; dst = d; lr = w; ld = l; sr1 = a; u1 = ua; sr2 = b; u2 = ub;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        checking = 1'b1;
        chk("rst_stall", stall, 0);
        chk("rst_sel1", sel1, 0);
        chk("rst_sel2", sel2, 0);
        chk("rst_count", cnt, 0);

        ins(1, 1, 1, 0, 6, 1, 7, 1); #1 chk("t1_stall_a", stall, 0); tick();
        ins(1, 2, 1, 0, 1, 1, 1, 1); #1 chk("t1_stall_b", stall, 0); tick();
        chk("t1_sel1", sel1, 1);
        chk("t1_sel2", sel2, 1);

        ins(1, 1, 1, 0, 0, 0, 0, 0); tick();
        ins(0, 0, 0, 0, 0, 0, 0, 0); tick();
        ins(1, 3, 1, 0, 1, 1, 4, 1); tick();
        chk("t2_sel1", sel1, 2);
        chk("t2_sel2", sel2, 0);
        ins(1, 4, 1, 0, 0, 0, 0, 0); tick();
        ins(0, 0, 0, 0, 0, 0, 0, 0); tick();
        tick();
        ins(1, 5, 1, 0, 4, 1, 4, 0); tick();
        chk("t2_gap3_sel1", sel1, 0);

        ins(1, 2, 1, 1, 0, 0, 0, 0); tick();
        ins(1, 5, 1, 0, 2, 1, 0, 1); #1 chk("t3_stall", stall, 1); tick();
        chk("t3_stall_drop", stall, 0);
        chk("t3_bubble_sel1", sel1, 0);
        tick();
        chk("t3_sel1", sel1, 2);
        chk("t3_sel2", sel2, 0);
        chk("t3_count", cnt, 1);

        ins(1, 1, 1, 0, 0, 0, 0, 0); tick();
        ins(1, 1, 1, 0, 0, 0, 0, 0); tick();
        ins(1, 6, 1, 0, 1, 1, 0, 0); tick();
        chk("t4_young_wins", sel1, 1);

        ins(1, 3, 1, 1, 0, 0, 0, 0); tick();
        ins(1, 4, 1, 0, 3, 1, 3, 1);
        adv = 1'b0;
        repeat (3) begin
            tick();
            chk("t5_hold_stall", stall, 1);
            chk("t5_hold_count", cnt, 1);
        end
        adv = 1'b1;
        flush = 1'b1;
        #1 chk("t5_flush_stall", stall, 0);
        tick();
        chk("t5_flush_sel1", sel1, 0);
        chk("t5_flush_sel2", sel2, 0);
        chk("t5_count", cnt, 1);
        flush = 1'b0;
        ins(0, 0, 0, 0, 0, 0, 0, 0); tick();

        ins(1, 2, 1, 1, 0, 0, 0, 0); tick();
        ins(1, 1, 1, 0, 2, 1, 0, 0); #1 chk("t6_stall", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_sel1", sel1, 0);
        chk("t6_rst_count", cnt, 0);

        repeat (20) begin
            ins(1, 2, 1, 1, 0, 0, 0, 0); tick();
            ins(1, 1, 1, 0, 2, 1, 0, 0); tick();
            tick();
        end
        ins(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("sat_count16", cnt, 20);
        chk("sat_count4", cnt4, 15);

        tick();
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
